// File: rtl/wshb_rr_arbiter_if.sv
// Wishbone B4 bus bundle shared by the masters and the SDRAM controller port.
interface wshb_if;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = DW / 8;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_ms;
  logic [DW-1:0] dat_sm;
  logic [SW-1:0] sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wshb_rr_arbiter.sv
// Two-master Wishbone arbiter: cyc ownership, round-robin tie-break, ack quantum.
module wshb_rr_arbiter #(
  parameter  int unsigned QUANTUM = 64,
  localparam int unsigned CNT_W   = $clog2(QUANTUM + 1)
) (
  input  logic       wshb_clk,
  input  logic       wshb_rst,
  wshb_if.slave      wshb_ifs0,
  wshb_if.slave      wshb_ifs1,
  wshb_if.master     wshb_ifm,
  output logic [1:0] grant
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] qcnt_q, qcnt_d;
  logic             last_q, last_d;

  logic             qsat;
  logic             end0;
  logic             end1;

  // Quantum is spent once the counter has saturated; classic or end-of-burst beats may yield.
  assign qsat = (qcnt_q == QMAX);
  assign end0 = (wshb_ifs0.cti == 3'b000) || (wshb_ifs0.cti == 3'b111);
  assign end1 = (wshb_ifs1.cti == 3'b000) || (wshb_ifs1.cti == 3'b111);

  // Owner, quantum counter and last-owner registers.
  always_ff @(posedge wshb_clk) begin
    if (wshb_rst) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      last_q  <= last_d;
    end
  end

  // Ownership decision: release hands over directly, quantum yield only on a burst boundary.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (wshb_ifs0.cyc && wshb_ifs1.cyc) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (wshb_ifs0.cyc) begin
          state_d = OWN0;
        end else if (wshb_ifs1.cyc) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!wshb_ifs0.cyc) begin
          state_d = wshb_ifs1.cyc ? OWN1 : IDLE;
        end else if (wshb_ifm.ack && end0 && qsat && wshb_ifs1.cyc) begin
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!wshb_ifs1.cyc) begin
          state_d = wshb_ifs0.cyc ? OWN0 : IDLE;
        end else if (wshb_ifm.ack && end1 && qsat && wshb_ifs0.cyc) begin
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      qcnt_d = '0;
    end else if (((state_q == OWN0) || (state_q == OWN1)) && wshb_ifm.ack && !qsat) begin
      qcnt_d = qcnt_q + CNT_W'(1);
    end

    if ((state_q == OWN0) && (state_d != OWN0)) begin
      last_d = 1'b0;
    end else if ((state_q == OWN1) && (state_d != OWN1)) begin
      last_d = 1'b1;
    end
  end

  // The owner encoding is the state register itself, so grant is a flop output.
  assign grant = state_q;

  // Bus steering from the registered owner; read data is broadcast, responses go to the owner only.
  always_comb begin
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.adr    = '0;
    wshb_ifm.dat_ms = '0;
    wshb_ifm.sel    = '0;
    wshb_ifm.cti    = 3'b000;
    wshb_ifm.bte    = 2'b00;

    wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    wshb_ifs0.ack    = 1'b0;
    wshb_ifs0.err    = 1'b0;
    wshb_ifs0.rty    = 1'b0;
    wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
    wshb_ifs1.ack    = 1'b0;
    wshb_ifs1.err    = 1'b0;
    wshb_ifs1.rty    = 1'b0;

    case (state_q)
      OWN0: begin
        wshb_ifm.cyc    = wshb_ifs0.cyc;
        wshb_ifm.stb    = wshb_ifs0.stb;
        wshb_ifm.we     = wshb_ifs0.we;
        wshb_ifm.adr    = wshb_ifs0.adr;
        wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
        wshb_ifm.sel    = wshb_ifs0.sel;
        wshb_ifm.cti    = wshb_ifs0.cti;
        wshb_ifm.bte    = wshb_ifs0.bte;
        wshb_ifs0.ack   = wshb_ifm.ack;
        wshb_ifs0.err   = wshb_ifm.err;
        wshb_ifs0.rty   = wshb_ifm.rty;
      end
      OWN1: begin
        wshb_ifm.cyc    = wshb_ifs1.cyc;
        wshb_ifm.stb    = wshb_ifs1.stb;
        wshb_ifm.we     = wshb_ifs1.we;
        wshb_ifm.adr    = wshb_ifs1.adr;
        wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
        wshb_ifm.sel    = wshb_ifs1.sel;
        wshb_ifm.cti    = wshb_ifs1.cti;
        wshb_ifm.bte    = wshb_ifs1.bte;
        wshb_ifs1.ack   = wshb_ifm.ack;
        wshb_ifs1.err   = wshb_ifm.err;
        wshb_ifs1.rty   = wshb_ifm.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// Bench for wshb_rr_arbiter: directed scenarios plus randomized traffic against a tenure model.
module tb_wshb_rr_arbiter;
  localparam int unsigned QUANTUM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;

  always #5 clk = ~clk;

  wshb_if m0_if ();
  wshb_if m1_if ();
  wshb_if s_if ();

  wshb_rr_arbiter #(.QUANTUM(QUANTUM)) dut (
    .wshb_clk  (clk),
    .wshb_rst  (rst),
    .wshb_ifs0 (m0_if),
    .wshb_ifs1 (m1_if),
    .wshb_ifm  (s_if),
    .grant     (grant)
  );

  // Master drive state
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic [2:0]  m_cti [2];
  int          req_left [2];
  int          beat [2];
  int          burst_len [2];

  assign m0_if.cyc = m_cyc[0];  assign m1_if.cyc = m_cyc[1];
  assign m0_if.stb = m_stb[0];  assign m1_if.stb = m_stb[1];
  assign m0_if.we  = m_we[0];   assign m1_if.we  = m_we[1];
  assign m0_if.adr = m_adr[0];  assign m1_if.adr = m_adr[1];
  assign m0_if.dat_ms = m_dat[0]; assign m1_if.dat_ms = m_dat[1];
  assign m0_if.sel = m_sel[0];  assign m1_if.sel = m_sel[1];
  assign m0_if.cti = m_cti[0];  assign m1_if.cti = m_cti[1];
  assign m0_if.bte = 2'b00;     assign m1_if.bte = 2'b00;

  // Slave model: registered ack after a programmable number of wait cycles.
  logic        s_ack;
  logic [31:0] s_dat;
  int          s_wait, s_dly;
  int          dly_min, dly_max;

  assign s_if.ack    = s_ack;
  assign s_if.dat_sm = s_dat;
  assign s_if.err    = 1'b0;
  assign s_if.rty    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_wait <= 0;
      s_dly  <= dly_min;
    end else begin
      s_ack <= 1'b0;
      if (s_if.cyc && s_if.stb && !s_ack) begin
        if (s_wait >= s_dly) begin
          s_ack  <= 1'b1;
          s_dat  <= s_if.adr ^ 32'hA5A5_A5A5;
          s_wait <= 0;
          s_dly  <= int'($urandom_range(dly_max, dly_min));
        end else begin
          s_wait <= s_wait + 1;
        end
      end else if (!s_if.cyc || !s_if.stb) begin
        s_wait <= 0;
      end
    end
  end

  // Reference model and scoreboard state
  int          exp_own;
  int          m_last;
  int          tenure;
  int          acks_seen [2];
  logic [31:0] last_dat [2];
  int          wait_acks [2];
  int          pend [2];
  bit          rand_mode;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input int o);
    if (o == 0) return 2'b01;
    if (o == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic new_txn(input int m);
    logic [31:0] r;
    r = $urandom();
    if (rand_mode) m_adr[m] = {m[0], r[30:0]};
    else           m_adr[m] = {m[0], 31'(beat[m] * 4)};
    m_dat[m] = $urandom();
    m_sel[m] = 4'hF;
    m_we[m]  = (m == 1) ? (rand_mode ? r[31] : 1'b1) : 1'b0;
    if (burst_len[m] > 0 && beat[m] < burst_len[m])
      m_cti[m] = (beat[m] == burst_len[m] - 1) ? 3'b111 : 3'b010;
    else if (rand_mode && r[0])
      m_cti[m] = 3'b111;
    else
      m_cti[m] = 3'b000;
  endtask

  task automatic start(input int m, input int n, input int blen);
    req_left[m]  = n;
    beat[m]      = 0;
    burst_len[m] = blen;
    m_cyc[m]     = 1'b1;
    m_stb[m]     = 1'b1;
    new_txn(m);
  endtask

  task automatic clear_masters();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
      m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_cti[m] = '0;
      req_left[m] = 0; beat[m] = 0; burst_len[m] = 0;
      wait_acks[m] = 0; pend[m] = 0;
    end
  endtask

  // Ownership rules in terms of tenure length rather than a saturating counter.
  task automatic model_update(input bit r, input bit ak);
    bit [1:0] c;
    int o, oth, nx;
    logic [2:0] ct;
    c = {m_cyc[1], m_cyc[0]};
    if (r) begin
      exp_own = -1; m_last = 1; tenure = 0;
      return;
    end
    if (exp_own < 0) begin
      if (c == 2'b11)   nx = (m_last == 1) ? 0 : 1;
      else if (c[0])    nx = 0;
      else if (c[1])    nx = 1;
      else              nx = -1;
    end else begin
      o   = exp_own;
      oth = 1 - o;
      ct  = m_cti[o];
      if (!c[o])
        nx = c[oth] ? oth : -1;
      else if (ak && (ct == 3'b000 || ct == 3'b111) && tenure + 1 >= int'(QUANTUM) && c[oth])
        nx = oth;
      else begin
        nx = o;
        if (ak) tenure++;
      end
      if (nx != o) begin
        m_last = o;
        tenure = 0;
      end
    end
    exp_own = nx;
  endtask

  // One clock: check mid-cycle, then advance model and masters after the edge.
  task automatic cycle();
    bit eack [2];
    bit bus_ack, r;
    int own;
    @(negedge clk);
    own = exp_own;
    bus_ack = s_ack;
    r = rst;
    chk("grant", 64'(grant), 64'(enc(own)));
    if (own >= 0) begin
      chk("bus_cyc", 64'(s_if.cyc), 64'(m_cyc[own]));
      chk("bus_stb", 64'(s_if.stb), 64'(m_stb[own]));
      chk("bus_adr", 64'(s_if.adr), 64'(m_adr[own]));
      chk("bus_we",  64'(s_if.we),  64'(m_we[own]));
      chk("bus_dat", 64'(s_if.dat_ms), 64'(m_dat[own]));
      chk("bus_cti", 64'(s_if.cti), 64'(m_cti[own]));
    end else begin
      chk("idle_cyc", 64'(s_if.cyc), 64'd0);
      chk("idle_stb", 64'(s_if.stb), 64'd0);
    end
    eack[0] = bus_ack && (own == 0);
    eack[1] = bus_ack && (own == 1);
    chk("ack0", 64'(m0_if.ack), 64'(eack[0]));
    chk("ack1", 64'(m1_if.ack), 64'(eack[1]));
    if (m0_if.ack) begin acks_seen[0]++; last_dat[0] = m0_if.dat_sm; end
    if (m1_if.ack) begin acks_seen[1]++; last_dat[1] = m1_if.dat_sm; end
    for (int m = 0; m < 2; m++) begin
      if (eack[m]) begin
        chk("ack_req", 64'(m_stb[m]), 64'd1);
        chk("ack_dat", 64'(m == 0 ? m0_if.dat_sm : m1_if.dat_sm), 64'(m_adr[m] ^ 32'hA5A5_A5A5));
      end
      if (m_cyc[m] && own != m && own >= 0 && bus_ack) wait_acks[m]++;
      if (own == m || !m_cyc[m]) wait_acks[m] = 0;
      if (m_stb[m]) pend[m]++; else pend[m] = 0;
      if (rand_mode) begin
        chk("wait_bound", 64'(wait_acks[m] > int'(QUANTUM)), 64'd0);
        chk("stb_timeout", 64'(pend[m] > 400), 64'd0);
      end
    end
    @(posedge clk);
    #1;
    model_update(r, bus_ack);
    if (!r) begin
      for (int m = 0; m < 2; m++) begin
        if (eack[m]) begin
          beat[m]++;
          req_left[m]--;
          if (req_left[m] <= 0) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
          end else begin
            m_stb[m] = rand_mode ? 1'($urandom_range(1, 0)) : 1'b1;
            if (m_stb[m]) new_txn(m);
          end
        end else if (m_cyc[m] && !m_stb[m]) begin
          if (!rand_mode || $urandom_range(1, 0) == 1) begin
            m_stb[m] = 1'b1;
            new_txn(m);
          end
        end else if (!m_cyc[m] && rand_mode && $urandom_range(3, 0) == 0) begin
          start(m, int'($urandom_range(6, 1)), 0);
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    clear_masters();
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
    acks_seen[0] = 0;
    acks_seen[1] = 0;
  endtask

  initial begin
    rst = 1'b1;
    rand_mode = 1'b0;
    dly_min = 0;
    dly_max = 0;
    clear_masters();
    exp_own = -1; m_last = 1; tenure = 0;
    acks_seen[0] = 0; acks_seen[1] = 0;
    @(posedge clk);
    #1;

    // 1: reset, then a single master-0 read
    repeat (3) begin
      cycle();
      chk("t1_rst_grant", 64'(grant), 64'd0);
      chk("t1_rst_cyc", 64'(s_if.cyc), 64'd0);
    end
    rst = 1'b0;
    start(0, 1, 0);
    cycle();
    chk("t1_grant", 64'(grant), 64'b01);
    cycle();
    chk("t1_no_ack_yet", 64'(acks_seen[0]), 64'd0);
    cycle();
    chk("t1_ack0", 64'(acks_seen[0]), 64'd1);
    chk("t1_ack1", 64'(acks_seen[1]), 64'd0);
    chk("t1_dat", 64'(last_dat[0]), 64'hA5A5_A5A5);
    repeat (3) cycle();
    chk("t1_idle", 64'(grant), 64'd0);

    // 2: simultaneous request after reset, hand-over without idle
    do_reset(2);
    start(0, 2, 0);
    start(1, 2, 0);
    cycle();
    chk("t2_first", 64'(grant), 64'b01);
    for (int i = 0; i < 50 && grant === 2'b01; i++) cycle();
    chk("t2_handover", 64'(grant), 64'b10);
    chk("t2_acks0", 64'(acks_seen[0]), 64'd2);
    for (int i = 0; i < 50 && grant !== 2'b00; i++) cycle();
    chk("t2_acks1", 64'(acks_seen[1]), 64'd2);

    // 3: quantum yield both ways
    do_reset(2);
    start(0, 100, 0);
    start(1, 100, 0);
    for (int i = 0; i < 100 && grant !== 2'b10; i++) cycle();
    chk("t3_yield_to1", 64'(grant), 64'b10);
    chk("t3_acks0", 64'(acks_seen[0]), 64'd4);
    chk("t3_acks1_pre", 64'(acks_seen[1]), 64'd0);
    chk("t3_bus_owner1", 64'(s_if.adr[31]), 64'd1);
    for (int i = 0; i < 100 && grant !== 2'b01; i++) cycle();
    chk("t3_yield_to0", 64'(grant), 64'b01);
    chk("t3_acks1", 64'(acks_seen[1]), 64'd4);
    chk("t3_acks0_hold", 64'(acks_seen[0]), 64'd4);

    // 4: an 8-beat burst is never split
    do_reset(2);
    start(1, 12, 8);
    cycle();
    chk("t4_grant1", 64'(grant), 64'b10);
    start(0, 50, 0);
    for (int i = 0; i < 200 && grant !== 2'b01; i++) cycle();
    chk("t4_yield", 64'(grant), 64'b01);
    chk("t4_beats", 64'(acks_seen[1]), 64'd8);

    // 5: reset while master 1 has a pending strobe
    clear_masters();
    dly_min = 5;
    dly_max = 5;
    do_reset(2);
    start(1, 1, 0);
    cycle();
    chk("t5_grant1", 64'(grant), 64'b10);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_grant", 64'(grant), 64'd0);
    chk("t5_cyc", 64'(s_if.cyc), 64'd0);
    chk("t5_noack", 64'(acks_seen[1]), 64'd0);
    clear_masters();
    dly_min = 0;
    dly_max = 0;
    start(0, 1, 0);
    start(1, 1, 0);
    cycle();
    chk("t5_both", 64'(grant), 64'b01);
    for (int i = 0; i < 50 && (m_cyc[0] || m_cyc[1]); i++) cycle();
    chk("t5_drain", 64'(acks_seen[0] + acks_seen[1]), 64'd2);

    // 6: randomized traffic with 0..5 wait-state slave
    dly_min = 0;
    dly_max = 5;
    do_reset(2);
    rand_mode = 1'b1;
    repeat (10000) cycle();
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
